// File: rtl/pipe_buffer_elastic.sv
// Elastic two-entry pipeline buffer with valid/ready handshake, skid register,
// synchronous flush and saturating stall/bubble counters. All state moves on the falling edge.
module pipe_buffer_elastic #(
    parameter int                DATA_W     = 138,
    parameter int                CNT_W      = 16,
    parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // state | meaning
    // EMPTY | nothing held, main_q stale
    // ONE   | head entry in main_q
    // FULL  | head in main_q, next entry in skid_q
    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        state_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  stall_q;
    logic [CNT_W-1:0]  bubble_q;
    logic              in_fire;
    logic              out_fire;

    // Handshake outputs depend only on registered state, never on the opposite side's inputs.
    assign in_ready   = (state_q != S_FULL);
    assign out_valid  = (state_q != S_EMPTY);
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else if (flush) begin
            state_q <= S_EMPTY;
            main_q  <= RESET_DATA;
            skid_q  <= RESET_DATA;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        state_q <= S_ONE;
                        main_q  <= in_data;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        state_q <= S_FULL;
                        skid_q  <= in_data;
                    end else if (out_fire) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        state_q <= S_ONE;
                        main_q  <= skid_q;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    // Counters look at pre-edge out_valid, so a flush edge can still register a stall.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clr_cnt) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && stall_q != CNT_MAX)
                stall_q <= stall_q + 1'b1;
            if (!out_valid && bubble_q != CNT_MAX)
                bubble_q <= bubble_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_buffer_elastic.sv
// Self-checking bench for pipe_buffer_elastic: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_pipe_buffer_elastic;

    localparam int              DW   = 16;
    localparam int              CW   = 4;
    localparam logic [DW-1:0]   RST_D = 16'hA55A;
    localparam int              CMAX = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          flush;
    logic          clr_cnt;
    logic [1:0]    occupancy;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] bubble_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [DW-1:0] mq[$];
    int            m_stall;
    int            m_bubble;

    pipe_buffer_elastic #(.DATA_W(DW), .CNT_W(CW), .RESET_DATA(RST_D)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .clr_cnt(clr_cnt), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mq.delete();
        m_stall  = 0;
        m_bubble = 0;
    endfunction

    // Advance the reference by one falling edge using the current inputs, then let the DUT take it.
    task automatic tick();
        bit ov, ir, inf, outf;
        ov   = (mq.size() != 0);
        ir   = (mq.size() < 2);
        inf  = in_valid && ir;
        outf = ov && out_ready;
        if (clr_cnt) begin
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (ov && !out_ready && m_stall < CMAX) m_stall++;
            if (!ov && m_bubble < CMAX) m_bubble++;
        end
        if (flush) mq.delete();
        else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(in_data);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic test_reset();
        // Fill to FULL, then pull reset asynchronously between edges.
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'h0011; tick();
        in_data   = 16'h0022; tick();
        in_valid  = 1'b0;
        n_total++;
        if (occupancy !== 2'd2) $display("FAIL reset_prefill_occ: got %0d expected 2", occupancy);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
        n_total++;
        if (out_data !== RST_D) $display("FAIL reset_out_data: got %h expected %h", out_data, RST_D);
        else n_pass++;
        n_total++;
        if (occupancy !== 2'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy);
        else n_pass++;
        n_total++;
        if (stall_cnt !== '0 || bubble_cnt !== '0)
            $display("FAIL reset_counters: got stall=%0d bubble=%0d expected 0/0", stall_cnt, bubble_cnt);
        else n_pass++;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        out_ready = 1'b1;
        for (int v = 1; v <= 8; v++) begin
            in_valid = 1'b1;
            in_data  = DW'(v);
            tick();
            n_total++;
            if (out_data !== DW'(v) || out_valid !== 1'b1)
                $display("FAIL pass_data_%0d: got %h/%b expected %h/1", v, out_data, out_valid, DW'(v));
            else n_pass++;
            n_total++;
            if (occupancy !== 2'd1) $display("FAIL pass_occ_%0d: got %0d expected 1", v, occupancy);
            else n_pass++;
        end
        in_valid = 1'b0;
        tick();
        n_total++;
        if (stall_cnt !== 4'd0) $display("FAIL pass_stall: got %0d expected 0", stall_cnt);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL pass_drain: got %b expected 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'h000A; tick();
        in_data   = 16'h000B; tick();
        n_total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0)
            $display("FAIL bp_full: got occ=%0d in_ready=%b expected 2/0", occupancy, in_ready);
        else n_pass++;
        in_data = 16'h000C; tick();
        n_total++;
        if (occupancy !== 2'd2 || out_data !== 16'h000A)
            $display("FAIL bp_hold: got occ=%0d data=%h expected 2/000a", occupancy, out_data);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'd2) $display("FAIL bp_stall: got %0d expected 2", stall_cnt);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        n_total++;
        if (out_data !== 16'h000B) $display("FAIL bp_order_b: got %h expected 000b", out_data);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (out_data !== 16'h000C || out_valid !== 1'b1)
            $display("FAIL bp_order_c: got %h/%b expected 000c/1", out_data, out_valid);
        else n_pass++;
        tick();
        n_total++;
        if (out_valid !== 1'b0 || stall_cnt !== 4'd2)
            $display("FAIL bp_drain: got valid=%b stall=%0d expected 0/2", out_valid, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_data = 16'h0001; tick();
        in_data   = 16'h0002; tick();
        in_data   = 16'h000D; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        n_total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0)
            $display("FAIL flush_empty: got occ=%0d valid=%b expected 0/0", occupancy, out_valid);
        else n_pass++;
        n_total++;
        if (out_data !== RST_D) $display("FAIL flush_data: got %h expected %h", out_data, RST_D);
        else n_pass++;
        n_total++;
        if (stall_cnt !== 4'(m_stall)) $display("FAIL flush_stall: got %0d expected %0d", stall_cnt, m_stall);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (out_valid !== 1'b0 || out_data === 16'h000D)
                $display("FAIL flush_no_d_%0d: got valid=%b data=%h expected 0/not 000d", i, out_valid, out_data);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        n_total++;
        if (bubble_cnt !== 4'd15) $display("FAIL sat_bubble: got %0d expected 15", bubble_cnt);
        else n_pass++;
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        n_total++;
        if (bubble_cnt !== 4'd0) $display("FAIL sat_clear: got %0d expected 0", bubble_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int e = 0; e < 10000; e++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 55);
            in_data   = DW'($urandom);
            flush     = ($urandom_range(0, 199) == 0);
            clr_cnt   = ($urandom_range(0, 299) == 0);
            #1;
            if (out_valid && out_ready && mq.size() != 0) begin
                n_total++;
                if (out_data !== mq[0]) begin
                    if (errs < 10) $display("FAIL rnd_data_e%0d: got %h expected %h", e, out_data, mq[0]);
                    errs++;
                end else n_pass++;
            end
            tick();
            n_total++;
            if (occupancy !== 2'(mq.size()) || out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < 2)) begin
                if (errs < 10)
                    $display("FAIL rnd_state_e%0d: got occ=%0d v=%b r=%b expected occ=%0d",
                             e, occupancy, out_valid, in_ready, mq.size());
                errs++;
            end else n_pass++;
            n_total++;
            if (stall_cnt !== 4'(m_stall) || bubble_cnt !== 4'(m_bubble)) begin
                if (errs < 10)
                    $display("FAIL rnd_cnt_e%0d: got stall=%0d bubble=%0d expected %0d/%0d",
                             e, stall_cnt, bubble_cnt, m_stall, m_bubble);
                errs++;
            end else n_pass++;
            if (mq.size() != 0) begin
                n_total++;
                if (out_data !== mq[0]) begin
                    if (errs < 10) $display("FAIL rnd_head_e%0d: got %h expected %h", e, out_data, mq[0]);
                    errs++;
                end else n_pass++;
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #23;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== RST_D)
            $display("FAIL init_reset: got v=%b r=%b occ=%0d data=%h expected 0/1/0/%h",
                     out_valid, in_ready, occupancy, out_data, RST_D);
        else n_pass++;
        rst_n = 1'b1;
        test_reset();
        test_passthrough();
        test_backpressure();
        test_flush();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
